// File: rtl/hex_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed hex display scanner.
package hex_scan_ctrl_pkg;

  // Active-low segment pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Each digit slot opens dark, then lights its digit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Bits needed to hold 0..value-1. Never returns less than 1, so a
  // single-digit build still gets a legal one-bit index register.
  function automatic int clog2(input int value);
    int width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/hex_scan_ctrl_scan_prescaler.sv
// Slot timer: counts PRESCALE cycles per digit slot and flags the end of
// the blanking interval and the end of the slot.
module scan_prescaler
  import hex_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 500
) (
  input  logic clock,
  input  logic reset,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = clog2(PRESCALE);

  logic [CNT_W-1:0] r_cnt;

  // Free-running slot counter, wrapping at the last cycle of the slot.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_cnt <= '0;
    end else if (slot_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign blank_done = (r_cnt == CNT_W'(BLANK - 1));
  assign slot_done  = (r_cnt == CNT_W'(PRESCALE - 1));

endmodule

// File: rtl/hex_scan_ctrl.sv
// Multiplexed hex display scanner. Holds a double-buffered display word,
// steps one digit per slot with a dark lead-in, feeds the external shared
// decoder and gates its segments onto the pins. New words commit only at
// frame boundaries so a frame never mixes old and new digits.
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 500
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value_in,
  input  logic                load,
  output logic                load_ready,
  input  logic [DIGITS-1:0]   blank_mask,
  output logic [3:0]          hex_code,
  input  logic [6:0]          seg_in,
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   digit_sel
);

  localparam int               IDX_W    = clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  scan_state_t         r_state;
  scan_state_t         w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_next;
  logic [4*DIGITS-1:0] r_active;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] w_active_next;
  logic                r_pending;
  logic                w_pending_next;
  logic                r_load_ready;
  logic [3:0]          r_hex_code;
  logic [3:0]          w_hex_code_next;
  logic [6:0]          r_seg_out;
  logic [6:0]          w_seg_out_next;
  logic [DIGITS-1:0]   r_digit_sel;
  logic [DIGITS-1:0]   w_digit_sel_next;
  logic                w_blank_done;
  logic                w_slot_done;
  logic                w_accept;
  logic                w_frame_end;
  logic                w_commit;
  logic                w_lit;

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) u_prescaler (
    .clock      (clock),
    .reset      (reset),
    .blank_done (w_blank_done),
    .slot_done  (w_slot_done)
  );

  // A load is taken only while the shadow buffer is advertised free.
  assign w_accept    = load & r_load_ready;
  // Last cycle of the last digit's slot: the next cycle starts a new frame.
  assign w_frame_end = (r_state == ST_SHOW) && w_slot_done && (r_idx == IDX_LAST);
  assign w_commit    = w_frame_end & r_pending;

  // Next-state, buffer and output decode; outputs are computed from the
  // next state so the registered pins line up with the state they belong to.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path
    // leaves one unassigned, which would infer a latch.
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_active_next    = r_active;
    w_pending_next   = r_pending;
    w_hex_code_next  = r_hex_code;
    w_seg_out_next   = SEG_OFF;
    w_digit_sel_next = '1;
    w_lit            = 1'b0;

    case (r_state)
      ST_BLANK: begin
        if (w_blank_done) w_state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (w_slot_done) begin
          w_state_next = ST_BLANK;
          w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
      default: w_state_next = ST_BLANK;
    endcase

    if (w_commit) begin
      w_active_next  = r_shadow;
      w_pending_next = 1'b0;
    end
    if (w_accept) w_pending_next = 1'b1;

    // Present the next digit's nibble as its blanking interval begins so the
    // shared decoder has settled before the digit is lit. At a frame start
    // this already sees the freshly committed word.
    if ((r_state == ST_SHOW) && w_slot_done) begin
      w_hex_code_next = w_active_next[4*w_idx_next +: 4];
    end

    w_lit          = (w_state_next == ST_SHOW) && !blank_mask[w_idx_next];
    w_seg_out_next = w_lit ? seg_in : SEG_OFF;
    for (int k = 0; k < DIGITS; k++) begin
      w_digit_sel_next[k] = !(w_lit && (IDX_W'(k) == w_idx_next));
    end
  end

  // State, buffers and registered pin drivers.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the display words are reset along with control state because
      // the first frame after reset must show zeros, not power-up garbage.
      r_state      <= ST_BLANK;
      r_idx        <= '0;
      r_active     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_load_ready <= 1'b1;
      r_hex_code   <= 4'h0;
      r_seg_out    <= SEG_OFF;
      r_digit_sel  <= '1;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_active    <= w_active_next;
      r_pending   <= w_pending_next;
      if (w_accept) r_shadow <= value_in;
      // Drops the cycle after an accept; after a commit it reopens only
      // once the buffer has been empty for a full cycle.
      r_load_ready <= ~(r_pending | w_pending_next);
      r_hex_code   <= w_hex_code_next;
      r_seg_out    <= w_seg_out_next;
      r_digit_sel  <= w_digit_sel_next;
    end
  end

  assign load_ready = r_load_ready;
  assign hex_code   = r_hex_code;
  assign seg_out    = r_seg_out;
  assign digit_sel  = r_digit_sel;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK=2.
// The decoder is a combinational table; the reference model tracks time
// since reset and derives slot, digit and phase arithmetically.
module tb_hex_scan_ctrl;

  localparam int D     = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = D * P;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic        load_ready;
  logic [3:0]  blank_mask;
  logic [3:0]  hex_code;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  digit_sel;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int          m_t;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pending;
  bit          m_ready;
  logic [3:0]  m_mask;

  always #5 clk = ~clk;

  // Shared decoder stand-in: active-low segments, bit order gfedcba.
  function automatic logic [6:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  assign seg_in = dec7(hex_code);

  hex_scan_ctrl #(
    .DIGITS   (D),
    .PRESCALE (P),
    .BLANK    (B)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .value_in   (value_in),
    .load       (load),
    .load_ready (load_ready),
    .blank_mask (blank_mask),
    .hex_code   (hex_code),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel)
  );

  // Model view of the current cycle.
  function automatic int cur_idx();
    return (m_t / P) % D;
  endfunction

  function automatic bit cur_lit();
    return ((m_t % P) >= B) && !m_mask[cur_idx()];
  endfunction

  function automatic logic [3:0] exp_hex();
    return m_active[4*cur_idx() +: 4];
  endfunction

  function automatic logic [3:0] exp_sel();
    logic [3:0] s;
    s = 4'b0001 << cur_idx();
    return cur_lit() ? ~s : 4'hF;
  endfunction

  function automatic logic [6:0] exp_seg();
    return cur_lit() ? dec7(exp_hex()) : 7'h7F;
  endfunction

  // Advance one clock: the model consumes the inputs present at the edge,
  // then outputs are sampled 1 ns later.
  task automatic step();
    logic        r_in;
    logic        ld_in;
    logic [15:0] v_in;
    logic [3:0]  mk_in;
    bit          acc;
    bit          was_pending;
    r_in  = reset;
    ld_in = load;
    v_in  = value_in;
    mk_in = blank_mask;
    @(posedge clk);
    m_mask = mk_in;
    if (r_in) begin
      m_t       = 0;
      m_active  = '0;
      m_shadow  = '0;
      m_pending = 1'b0;
      m_ready   = 1'b1;
    end else begin
      acc         = ld_in && m_ready;
      was_pending = m_pending;
      m_t         = m_t + 1;
      if ((m_t % FRAME) == 0 && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (acc) begin
        m_shadow  = v_in;
        m_pending = 1'b1;
      end
      m_ready = !m_pending && !was_pending;
    end
    #1;
  endtask

  task automatic run_to(input int n);
    while (m_t < n) step();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load       = 1'b0;
    value_in   = '0;
    blank_mask = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    load       = 1'b0;
    value_in   = '0;
    blank_mask = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (digit_sel !== 4'hF) begin
        n_err++; $display("FAIL reset_sel hold=%0d got=%h want=%h", i, digit_sel, 4'hF);
      end
      n_vec++;
      if (seg_out !== 7'h7F) begin
        n_err++; $display("FAIL reset_seg hold=%0d got=%h want=%h", i, seg_out, 7'h7F);
      end
      n_vec++;
      if (load_ready !== 1'b1) begin
        n_err++; $display("FAIL reset_ready hold=%0d got=%b want=1", i, load_ready);
      end
      n_vec++;
      if (hex_code !== 4'h0) begin
        n_err++; $display("FAIL reset_hex hold=%0d got=%h want=0", i, hex_code);
      end
    end
    reset = 1'b0;
    run_to(1);
    n_vec++;
    if (digit_sel !== 4'hF) begin
      n_err++; $display("FAIL first_blank cyc=1 got=%h want=%h", digit_sel, 4'hF);
    end
    run_to(2);
    n_vec++;
    if (digit_sel !== 4'b1110) begin
      n_err++; $display("FAIL first_show cyc=2 got=%b want=1110", digit_sel);
    end
    n_vec++;
    if (hex_code !== 4'h0 || seg_out !== 7'h40) begin
      n_err++; $display("FAIL first_show_code cyc=2 got=%h/%h want=0/40", hex_code, seg_out);
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] want_hex [4];
    logic [3:0] want_sel;
    want_hex[0] = 4'h4; want_hex[1] = 4'h3; want_hex[2] = 4'h2; want_hex[3] = 4'h1;
    do_reset();
    run_to(5);
    load = 1'b1; value_in = 16'h1234;
    step();
    load = 1'b0;
    n_vec++;
    if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL load_ready_drop cyc=6 got=%b want=0", load_ready);
    end
    run_to(31);
    n_vec++;
    if (hex_code !== 4'h0) begin
      n_err++; $display("FAIL pre_commit_hex cyc=31 got=%h want=0", hex_code);
    end
    run_to(32);
    n_vec++;
    if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL commit_ready cyc=32 got=%b want=0", load_ready);
    end
    run_to(33);
    n_vec++;
    if (load_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_reopen cyc=33 got=%b want=1", load_ready);
    end
    for (int k = 0; k < D; k++) begin
      run_to(32 + P * k + B);
      want_sel    = 4'hF;
      want_sel[k] = 1'b0;
      n_vec++;
      if (hex_code !== want_hex[k]) begin
        n_err++; $display("FAIL commit_hex digit=%0d got=%h want=%h", k, hex_code, want_hex[k]);
      end
      n_vec++;
      if (digit_sel !== want_sel || seg_out !== dec7(want_hex[k])) begin
        n_err++; $display("FAIL commit_pins digit=%0d got=%b/%h want=%b/%h",
                          k, digit_sel, seg_out, want_sel, dec7(want_hex[k]));
      end
    end
  endtask

  task automatic test_load_while_pending();
    do_reset();
    run_to(5);
    load = 1'b1; value_in = 16'h1234;
    step();
    load = 1'b0;
    run_to(10);
    load = 1'b1; value_in = 16'hABCD;
    step();
    load = 1'b0;
    run_to(31);
    load = 1'b1; value_in = 16'hABCD;
    step();
    load = 1'b0;
    value_in = '0;
    n_vec++;
    if (hex_code !== 4'h4) begin
      n_err++; $display("FAIL pending_commit_hex cyc=32 got=%h want=4", hex_code);
    end
    run_to(64);
    n_vec++;
    if (hex_code !== 4'h4) begin
      n_err++; $display("FAIL pending_ignored cyc=64 got=%h want=4", hex_code);
    end
    run_to(64 + P);
    n_vec++;
    if (hex_code !== 4'h3) begin
      n_err++; $display("FAIL pending_ignored cyc=72 got=%h want=3", hex_code);
    end
  endtask

  task automatic test_mask();
    logic [3:0] want_sel;
    logic [6:0] want_seg;
    int         slot;
    int         pos;
    do_reset();
    blank_mask = 4'b0100;
    for (int c = 0; c < FRAME; c++) begin
      run_to(c);
      slot        = c / P;
      pos         = c % P;
      want_sel    = 4'hF;
      want_seg    = 7'h7F;
      if (pos >= B && slot != 2) begin
        want_sel[slot] = 1'b0;
        want_seg       = dec7(4'h0);
      end
      n_vec++;
      if (digit_sel !== want_sel || seg_out !== want_seg) begin
        n_err++; $display("FAIL mask cyc=%0d got=%b/%h want=%b/%h", c, digit_sel, seg_out, want_sel, want_seg);
      end
    end
    blank_mask = 4'b0000;
    run_to(FRAME + 2 * P + B + 1);
    n_vec++;
    if (digit_sel !== 4'b1011) begin
      n_err++; $display("FAIL unmask cyc=%0d got=%b want=1011", m_t, digit_sel);
    end
  endtask

  task automatic test_load_boundary();
    do_reset();
    run_to(FRAME - 1);
    load = 1'b1; value_in = 16'h00FF;
    step();
    load = 1'b0;
    n_vec++;
    if (hex_code !== 4'h0) begin
      n_err++; $display("FAIL boundary_digit0 cyc=32 got=%h want=0", hex_code);
    end
    n_vec++;
    if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL boundary_ready cyc=32 got=%b want=0", load_ready);
    end
    run_to(FRAME + P);
    n_vec++;
    if (hex_code !== 4'h0) begin
      n_err++; $display("FAIL boundary_digit1 cyc=40 got=%h want=0", hex_code);
    end
    run_to(2 * FRAME);
    n_vec++;
    if (hex_code !== 4'hF) begin
      n_err++; $display("FAIL boundary_commit cyc=64 got=%h want=F", hex_code);
    end
    run_to(2 * FRAME + P);
    n_vec++;
    if (hex_code !== 4'hF) begin
      n_err++; $display("FAIL boundary_digit1_new cyc=72 got=%h want=F", hex_code);
    end
    run_to(2 * FRAME + 1);
  endtask

  task automatic test_mid_slot_reset();
    do_reset();
    run_to(5);
    load = 1'b1; value_in = 16'h1234;
    step();
    load = 1'b0;
    run_to(33);
    load = 1'b1; value_in = 16'h5678;
    step();
    load = 1'b0;
    run_to(FRAME + 2 * P + 3);
    n_vec++;
    if (digit_sel !== 4'b1011 || hex_code !== 4'h2) begin
      n_err++; $display("FAIL pre_reset_show got=%b/%h want=1011/2", digit_sel, hex_code);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (digit_sel !== 4'hF || seg_out !== 7'h7F) begin
      n_err++; $display("FAIL midreset_pins got=%b/%h want=1111/7f", digit_sel, seg_out);
    end
    n_vec++;
    if (load_ready !== 1'b1 || hex_code !== 4'h0) begin
      n_err++; $display("FAIL midreset_ctrl got=%b/%h want=1/0", load_ready, hex_code);
    end
    run_to(P + B);
    n_vec++;
    if (hex_code !== 4'h0 || digit_sel !== 4'b1101) begin
      n_err++; $display("FAIL midreset_active got=%h/%b want=0/1101", hex_code, digit_sel);
    end
    run_to(FRAME + 1);
    n_vec++;
    if (hex_code !== 4'h0) begin
      n_err++; $display("FAIL midreset_no_commit got=%h want=0", hex_code);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      load     = ($urandom_range(0, 5) == 0);
      value_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
      step();
      n_vec++;
      if (digit_sel !== exp_sel()) begin
        n_err++; $display("FAIL rand_sel t=%0d got=%b want=%b", m_t, digit_sel, exp_sel());
      end
      n_vec++;
      if (seg_out !== exp_seg()) begin
        n_err++; $display("FAIL rand_seg t=%0d got=%h want=%h", m_t, seg_out, exp_seg());
      end
      n_vec++;
      if (hex_code !== exp_hex()) begin
        n_err++; $display("FAIL rand_hex t=%0d got=%h want=%h", m_t, hex_code, exp_hex());
      end
      n_vec++;
      if (load_ready !== m_ready) begin
        n_err++; $display("FAIL rand_ready t=%0d got=%b want=%b", m_t, load_ready, m_ready);
      end
    end
    reset = 1'b0;
    load  = 1'b0;
  endtask

  initial begin
    m_t = 0;
    test_reset();
    test_load_commit();
    test_load_while_pending();
    test_mask();
    test_load_boundary();
    test_mid_slot_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation exceeded time limit at t=%0d", m_t);
    $fatal(1, "watchdog");
  end

endmodule
